console_uart_tx: RTL and testbench

Serial transmitter that sits directly downstream of the Wrapper console output port. It accepts bytes on the CONSOLE_OUT / CONSOLE_OUT_valid / CONSOLE_OUT_ready handshake and buffers them in a small FIFO. It then serialises each byte as 8N1 UART frames on TX. All timing is derived from the single system clock by a bit-period counter.

---
 rtl/console_uart_tx.sv | 150 +++++++++++++++
 tb/tb_console_uart_tx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/console_uart_tx.sv
// Console UART transmitter: buffers bytes from the Wrapper console port in a
// small FIFO and serialises them as 8N1 frames on TX.
module console_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [7:0]                    CONSOLE_OUT,
  input  logic                          CONSOLE_OUT_valid,
  output logic                          CONSOLE_OUT_ready,
  output logic                          TX,
  output logic                          BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BCNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]        state, state_nxt;
  logic              tx_q, tx_nxt;
  logic              busy_q, busy_nxt;
  logic [BCNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [2:0]        bit_idx, bit_idx_nxt;
  logic [7:0]        shift, shift_nxt;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [7:0]        mem [FIFO_DEPTH];
  logic              push, pop, bit_done;

  assign CONSOLE_OUT_ready = !RESET && (count < CNT_FULL);
  assign push              = CONSOLE_OUT_valid && CONSOLE_OUT_ready;
  assign bit_done          = (bit_cnt == BIT_LAST);

  assign TX         = tx_q;
  assign BUSY       = busy_q;
  assign FIFO_COUNT = count;

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= S_IDLE;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
    end else begin
      state   <= state_nxt;
      tx_q    <= tx_nxt;
      busy_q  <= busy_nxt;
      bit_cnt <= bit_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      count   <= count_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // FIFO storage; push already excludes reset via ready
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= CONSOLE_OUT;
  end

  // Next-state logic; frames chain STOP->START with no idle gap
  always_comb begin
    state_nxt   = state;
    tx_nxt      = tx_q;
    bit_cnt_nxt = bit_cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    pop         = 1'b0;

    case (state)
      S_IDLE: begin
        tx_nxt      = 1'b1;
        bit_cnt_nxt = '0;
        if (count != '0) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          state_nxt = S_START;
          tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (bit_done) begin
          bit_cnt_nxt = '0;
          bit_idx_nxt = '0;
          state_nxt   = S_DATA;
          tx_nxt      = shift[0];
        end else begin
          bit_cnt_nxt = bit_cnt + BCNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_done) begin
          bit_cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = S_STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            shift_nxt   = {1'b0, shift[7:1]};
            tx_nxt      = shift[1];
          end
        end else begin
          bit_cnt_nxt = bit_cnt + BCNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_done) begin
          bit_cnt_nxt = '0;
          if (count != '0) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            state_nxt = S_START;
            tx_nxt    = 1'b0;
          end else begin
            state_nxt = S_IDLE;
            tx_nxt    = 1'b1;
          end
        end else begin
          bit_cnt_nxt = bit_cnt + BCNT_W'(1);
        end
      end
      default: begin
        state_nxt   = S_IDLE;
        tx_nxt      = 1'b1;
        bit_cnt_nxt = '0;
      end
    endcase

    count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    busy_nxt  = (state_nxt != S_IDLE) || (count_nxt != '0);
  end

endmodule

// File: tb/tb_console_uart_tx.sv
// Bench for console_uart_tx: directed table for one frame, hand-written corner
// sequences, and random traffic checked cycle by cycle against a frame-level model.
module tb_console_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] CONSOLE_OUT;
  logic       CONSOLE_OUT_valid;
  logic       CONSOLE_OUT_ready;
  logic       TX;
  logic       BUSY;
  logic [2:0] FIFO_COUNT;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  console_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .CONSOLE_OUT       (CONSOLE_OUT),
    .CONSOLE_OUT_valid (CONSOLE_OUT_valid),
    .CONSOLE_OUT_ready (CONSOLE_OUT_ready),
    .TX                (TX),
    .BUSY              (BUSY),
    .FIFO_COUNT        (FIFO_COUNT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Frame-level reference: byte queue, occupancy, and cycles left in the current frame
  logic [7:0] m_q[$];
  logic [7:0] m_cur = 8'h00;
  int         m_cnt = 0;
  int         m_left = 0;
  bit         seen_rst = 1'b0;
  int         max_cnt = 0;
  int         rdy_low = 0;
  logic       s_r, s_v, s_rdy, e_rdy;
  logic [7:0] s_d;

  function automatic logic exp_tx();
    int b;
    if (m_left == 0) return 1'b1;
    b = (FRAME - m_left) / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  always begin
    @(posedge CLK);
    s_r = RESET; s_v = CONSOLE_OUT_valid; s_d = CONSOLE_OUT; s_rdy = CONSOLE_OUT_ready;
    e_rdy = !s_r && (m_cnt < DEPTH);
    if (seen_rst) chk("mon_ready", s_rdy, e_rdy);
    if (s_r) begin
      seen_rst = 1'b1;
      m_cnt = 0; m_left = 0; m_q.delete();
    end else if (seen_rst) begin
      if (m_left <= 1 && m_cnt > 0) begin
        m_cur = m_q.pop_front(); m_left = FRAME; m_cnt--;
      end else if (m_left > 0) begin
        m_left--;
      end
      if (s_v && e_rdy) begin m_q.push_back(s_d); m_cnt++; end
    end
    #1;
    if (seen_rst) begin
      chk("mon_tx", TX, exp_tx());
      chk("mon_busy", BUSY, (m_left > 0) || (m_cnt != 0));
      chk("mon_count", FIFO_COUNT, m_cnt);
      if (int'(FIFO_COUNT) > max_cnt) max_cnt = int'(FIFO_COUNT);
      if (!CONSOLE_OUT_ready) rdy_low++;
    end
  end

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       tx;
    logic       busy;
    logic [2:0] cnt;
    logic       rdy;
  } vec_t;

  vec_t       tbl [45];
  logic [7:0] src[$];
  int         tf, tb, errs;

  task automatic send(input bit gaps);
    int  guard = 0;
    bit  acc;
    foreach (src[i]) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin
        CONSOLE_OUT_valid = 1'b0; CONSOLE_OUT = 8'($urandom); step();
      end
      CONSOLE_OUT_valid = 1'b1; CONSOLE_OUT = src[i];
      acc = 1'b0;
      while (!acc && guard < 5000) begin
        acc = CONSOLE_OUT_ready;
        step();
        guard++;
      end
    end
    CONSOLE_OUT_valid = 1'b0;
    chk("send_timeout", guard < 5000, 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (BUSY && n < 2000) begin step(); n++; end
    chk("idle_timeout", BUSY, 1'b0);
  endtask

  task automatic track();
    if (tf < 0 && TX == 1'b0) tf = cyc;
    if (tf >= 0 && tb < 0 && BUSY == 1'b0) tb = cyc;
  endtask

  initial begin
    logic [7:0] basic;
    int b;
    basic = 8'h41;
    for (int i = 0; i < 45; i++) begin
      b = (i - 1) / CPB;
      tbl[i].v    = (i == 0);
      tbl[i].d    = basic;
      tbl[i].busy = (i <= FRAME);
      tbl[i].cnt  = (i == 0) ? 3'd1 : 3'd0;
      tbl[i].rdy  = 1'b1;
      if (i < 1 || i > FRAME) tbl[i].tx = 1'b1;
      else if (b == 0)        tbl[i].tx = 1'b0;
      else if (b == 9)        tbl[i].tx = 1'b1;
      else                    tbl[i].tx = basic[b-1];
    end

    RESET = 1'b1; CONSOLE_OUT_valid = 1'b0; CONSOLE_OUT = 8'h00;
    step(); step();
    chk("rst_ready", CONSOLE_OUT_ready, 1'b0);
    chk("rst_tx", TX, 1'b1);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_count", FIFO_COUNT, 3'd0);
    RESET = 1'b0;
    #1;
    chk("ready_after_rst", CONSOLE_OUT_ready, 1'b1);

    // Single 0x41 frame, cycle by cycle
    for (int i = 0; i < 45; i++) begin
      CONSOLE_OUT_valid = tbl[i].v; CONSOLE_OUT = tbl[i].d;
      step();
      chk("basic_tx", TX, tbl[i].tx);
      chk("basic_busy", BUSY, tbl[i].busy);
      chk("basic_count", FIFO_COUNT, tbl[i].cnt);
      chk("basic_ready", CONSOLE_OUT_ready, tbl[i].rdy);
    end

    // Back-to-back frames
    tf = -1; tb = -1; max_cnt = 0;
    CONSOLE_OUT_valid = 1'b1;
    CONSOLE_OUT = 8'h55; step(); track();
    CONSOLE_OUT = 8'hAA; step(); track();
    CONSOLE_OUT = 8'h0F; step(); track();
    CONSOLE_OUT_valid = 1'b0;
    for (int n = 0; n < 300 && tb < 0; n++) begin step(); track(); end
    chk("b2b_peak", max_cnt, 2);
    chk("b2b_length", tb - tf, 3 * FRAME);

    // Push on the same edge as a STOP->START pop
    CONSOLE_OUT_valid = 1'b1;
    CONSOLE_OUT = 8'h11; step();
    CONSOLE_OUT = 8'h22; step();
    CONSOLE_OUT = 8'h44; step();
    CONSOLE_OUT_valid = 1'b0;
    repeat (FRAME - 2) step();
    chk("pp_count_before", FIFO_COUNT, 3'd2);
    chk("pp_ready", CONSOLE_OUT_ready, 1'b1);
    CONSOLE_OUT_valid = 1'b1; CONSOLE_OUT = 8'h33;
    step();
    CONSOLE_OUT_valid = 1'b0;
    chk("pp_count_after", FIFO_COUNT, 3'd2);
    wait_idle();

    // Backpressure with valid held high
    max_cnt = 0; rdy_low = 0;
    src.delete();
    for (int i = 1; i <= 8; i++) src.push_back(8'(i));
    send(1'b0);
    wait_idle();
    chk("full_peak", max_cnt, DEPTH);
    chk("full_backpressure", rdy_low > 0, 1'b1);

    // Reset during data bit 3, with a second byte still buffered
    CONSOLE_OUT_valid = 1'b1;
    CONSOLE_OUT = 8'hC3; step();
    CONSOLE_OUT = 8'h99; step();
    CONSOLE_OUT_valid = 1'b0;
    repeat (16) step();
    RESET = 1'b1;
    #1;
    chk("mid_ready_in_rst", CONSOLE_OUT_ready, 1'b0);
    step();
    RESET = 1'b0;
    chk("mid_tx", TX, 1'b1);
    chk("mid_count", FIFO_COUNT, 3'd0);
    chk("mid_busy", BUSY, 1'b0);
    #1;
    chk("mid_ready_after", CONSOLE_OUT_ready, 1'b1);
    errs = 0;
    repeat (60) begin
      step();
      if (TX !== 1'b1 || BUSY !== 1'b0) errs++;
    end
    chk("mid_quiet", errs, 0);

    // Single bytes across pointer wrap-around
    for (int i = 0; i < 9; i++) begin
      src.delete();
      src.push_back(8'(8'h10 + i));
      send(1'b0);
      wait_idle();
      chk("wrap_count", FIFO_COUNT, 3'd0);
    end

    // Random traffic with idle gaps and junk on the bus while not valid
    src.delete();
    for (int i = 0; i < 40; i++) src.push_back(8'($urandom));
    send(1'b1);
    wait_idle();
    chk("rand_drained", FIFO_COUNT, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
